implication_queue: RTL

IMPLICATION_QUEUE -- requirements
Module: implication_queue

---
 rtl/implication_queue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/implication_queue.sv
// implication_queue: FIFO of BCP implications drained into the assign/value tables.
// Defining CONFLICT_CHECK_EN enables the opposite-polarity CONFLICT halt.
module implication_queue #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bcp,
   input  logic [11:0] bcp_var,
   input  logic        bcp_value,
   output logic        bcp_ready,
   input  logic [11:0] rd_addr1,
   input  logic [11:0] rd_addr2,
   output logic        rd_assigned1,
   output logic        rd_value1,
   output logic        rd_assigned2,
   output logic        rd_value2,
   input  logic        unassign,
   input  logic [11:0] unassign_var,
   output logic        conflict,
   output logic [11:0] conflict_var,
   input  logic        conflict_clear,
   output logic        busy,
   output logic        overflow,
   output logic [12:0] assigned_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_CONFLICT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [12:0]   r_fifo [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [AW:0]   w_occ;
   logic [AW:0]   w_next_occ;
   // Bit 0 of each table is never written, so address 0 always reads 0/0.
   logic [4095:0] r_assign;
   logic [4095:0] r_value;
   logic [12:0]   r_count;
   logic          r_conflict;
   logic [11:0]   r_conflict_var;
   logic          r_overflow;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_unassign;
   logic          w_conflict_hit;
   logic [11:0]   w_head_var;
   logic          w_head_val;
   logic          w_head_assigned;
   logic          w_head_differs;

   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_occ      = r_wr_ptr - r_rd_ptr;
   assign {w_head_var, w_head_val} = r_fifo[r_rd_ptr[AW-1:0]];
   assign w_head_assigned = r_assign[w_head_var];
   assign w_head_differs  = (r_value[w_head_var] != w_head_val);
   assign w_pop      = (r_state != ST_CONFLICT) && !w_empty;

`ifdef CONFLICT_CHECK_EN
   assign w_conflict_hit = w_pop && w_head_assigned && w_head_differs;
`else
   assign w_conflict_hit = 1'b0;
`endif

   // A push coinciding with a conflicting pop is swallowed by the flush.
   assign bcp_ready  = (r_state != ST_CONFLICT) && !w_full;
   assign w_push     = bcp && bcp_ready && (bcp_var != 12'd0) && !w_conflict_hit;
   assign w_unassign = unassign && (unassign_var != 12'd0) &&
                       ((r_state == ST_IDLE) || (r_state == ST_CONFLICT));
   assign w_next_occ = w_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

   assign rd_assigned1   = r_assign[rd_addr1];
   assign rd_value1      = r_value[rd_addr1];
   assign rd_assigned2   = r_assign[rd_addr2];
   assign rd_value2      = r_value[rd_addr2];
   assign conflict       = r_conflict;
   assign conflict_var   = r_conflict_var;
   assign overflow       = r_overflow;
   assign assigned_count = r_count;
   assign busy           = !w_empty || (r_state != ST_IDLE);

   // Next-state decode: halt on conflict, otherwise track FIFO occupancy.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_CONFLICT: begin
            if (conflict_clear) w_next_state = ST_IDLE;
            else                w_next_state = ST_CONFLICT;
         end
         ST_IDLE, ST_DRAIN: begin
            if (w_conflict_hit)             w_next_state = ST_CONFLICT;
            else if (w_next_occ != PTR_ZERO) w_next_state = ST_DRAIN;
            else                             w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State, FIFO pointers, conflict report and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_wr_ptr       <= PTR_ZERO;
         r_rd_ptr       <= PTR_ZERO;
         r_conflict     <= 1'b0;
         r_conflict_var <= 12'd0;
         r_overflow     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_conflict_hit) begin
            r_rd_ptr <= r_wr_ptr;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_conflict_hit) begin
            r_conflict     <= 1'b1;
            r_conflict_var <= w_head_var;
         end else if ((r_state == ST_CONFLICT) && conflict_clear) begin
            r_conflict     <= 1'b0;
            r_conflict_var <= 12'd0;
         end
         if (bcp && (r_state != ST_CONFLICT) && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // FIFO storage; validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= {bcp_var, bcp_value};
   end

   // Assignment tables and count; pops and honoured unassigns never coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_assign <= {4096{1'b0}};
         r_value  <= {4096{1'b0}};
         r_count  <= 13'd0;
      end else if (w_pop) begin
         if (!w_head_assigned) begin
            r_assign[w_head_var] <= 1'b1;
            r_value[w_head_var]  <= w_head_val;
            r_count              <= r_count + 13'd1;
         end else if (w_head_differs && !w_conflict_hit) begin
            r_value[w_head_var]  <= w_head_val;
         end
      end else if (w_unassign) begin
         r_assign[unassign_var] <= 1'b0;
         r_value[unassign_var]  <= 1'b0;
         if (r_assign[unassign_var]) r_count <= r_count - 13'd1;
      end
   end
endmodule
